// File: rtl/fwd_hazard_unit_if.sv
// Bundle between ID and the forwarding/interlock unit.
// The unit side uses the slave modport; the ID side uses the master modport.
interface fwd_hazard_unit_if #(
  parameter int REGW    = 5,
  parameter int NSTAGES = 3,
  parameter int CNTW    = 16
);
  localparam int FWDW = $clog2(NSTAGES + 1);

  logic            IDVALID;
  logic [REGW-1:0] IDRS;
  logic [REGW-1:0] IDRT;
  logic            USERS;
  logic            USERT;
  logic [REGW-1:0] IDDES;
  logic            IDWREG;
  logic            IDM2REG;
  logic            FLUSH;
  logic            CLRCNT;
  logic [FWDW-1:0] FWDA;
  logic [FWDW-1:0] FWDB;
  logic            STALL;
  logic            ISSUE;
  logic [CNTW-1:0] STALLCNT;

  modport master (
    output IDVALID, IDRS, IDRT, USERS, USERT,
    output IDDES, IDWREG, IDM2REG, FLUSH, CLRCNT,
    input  FWDA, FWDB, STALL, ISSUE, STALLCNT
  );

  modport slave (
    input  IDVALID, IDRS, IDRT, USERS, USERT,
    input  IDDES, IDWREG, IDM2REG, FLUSH, CLRCNT,
    output FWDA, FWDB, STALL, ISSUE, STALLCNT
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use interlock driven by a scoreboard
// of in-flight destinations over NSTAGES post-decode stages.
module fwd_hazard_unit #(
  parameter int REGW    = 5,
  parameter int NSTAGES = 3,
  parameter int LOADLAT = 2,
  parameter int CNTW    = 16
) (
  input logic              CLK,
  input logic              RSTN,
  fwd_hazard_unit_if.slave hz
);
  localparam int FWDW = $clog2(NSTAGES + 1);

  if (NSTAGES < 1 || NSTAGES > 7 ||
      LOADLAT < 1 || LOADLAT > NSTAGES ||
      REGW < 1 || CNTW < 1) begin : g_bad_param
    $error("fwd_hazard_unit: parameter out of range");
  end

  typedef struct packed {
    logic            v;
    logic [REGW-1:0] des;
    logic            wreg;
    logic            m2reg;
  } ent_t;

  typedef struct packed {
    logic            hit;
    logic            rdy;
    logic [FWDW-1:0] sel;
  } match_t;

  ent_t [NSTAGES:1] e_q;
  ent_t [NSTAGES:1] e_d;
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;

  match_t ma;
  match_t mb;
  logic   hazard;
  logic   live;
  logic   stall;
  logic   issue;

  // Scan oldest to youngest so the youngest match is left standing.
  function automatic match_t lookup(
    input ent_t [NSTAGES:1] sb,
    input logic [REGW-1:0]  r,
    input logic             use_r
  );
    match_t m;
    m     = '0;
    m.rdy = 1'b1;
    for (int k = NSTAGES; k >= 1; k--) begin
      if (use_r && (r != '0) && sb[k].v &&
          sb[k].wreg && (sb[k].des == r)) begin
        m.hit = 1'b1;
        m.sel = FWDW'(k);
        m.rdy = ~sb[k].m2reg | (k >= LOADLAT);
      end
    end
    return m;
  endfunction

  always_comb begin
    ma     = lookup(e_q, hz.IDRS, hz.USERS);
    mb     = lookup(e_q, hz.IDRT, hz.USERT);
    hazard = (ma.hit & ~ma.rdy) | (mb.hit & ~mb.rdy);
    live   = hz.IDVALID & ~hz.FLUSH;
    stall  = live & hazard;
    issue  = live & ~hazard;
  end

  assign hz.STALL    = stall;
  assign hz.ISSUE    = issue;
  assign hz.FWDA     = (issue && ma.hit) ? ma.sel : '0;
  assign hz.FWDB     = (issue && mb.hit) ? mb.sel : '0;
  assign hz.STALLCNT = cnt_q;

  always_comb begin
    e_d = '0;
    if (issue) begin
      e_d[1].v     = 1'b1;
      e_d[1].des   = hz.IDDES;
      e_d[1].wreg  = hz.IDWREG;
      e_d[1].m2reg = hz.IDM2REG;
    end
    for (int k = 2; k <= NSTAGES; k++) begin
      e_d[k] = e_q[k-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hz.CLRCNT) begin
      cnt_d = '0;
    end else if (stall && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      e_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      cnt_q <= cnt_d;
    end
  end
endmodule
